// File: rtl/camera_pkg.sv
// camera_pkg: shared states, pattern codes and pixel width for the camera_sim video source
package camera_pkg;
  localparam int PIXEL_BITS = 10;
  typedef enum logic [2:0] {IDLE, FRONT, LINE, HBLANK, VBLANK} state_t;
  localparam logic [1:0] PAT_RAMP    = 2'b00;
  localparam logic [1:0] PAT_COORD   = 2'b01;
  localparam logic [1:0] PAT_CHECK   = 2'b10;
  localparam logic [1:0] PAT_FRAMEID = 2'b11;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b ? a : b) > c ? (a > b ? a : b) : c;
  endfunction
endpackage

// File: rtl/camera_sim_pattern.sv
// camera_sim_pattern: combinational test-pattern pixel value from raster position and frame id
module camera_sim_pattern
  import camera_pkg::*;
#(
  parameter int LW = 1,
  parameter int CW = 1
) (
  input  logic [1:0]            pattern,
  input  logic [LW-1:0]         line,
  input  logic [CW-1:0]         col,
  input  logic [PIXEL_BITS-1:0] pix,
  input  logic [PIXEL_BITS-1:0] frame_id,
  output logic [PIXEL_BITS-1:0] value
);
  logic [PIXEL_BITS-1:0] ly, cx, coord;
  assign ly = PIXEL_BITS'(line) + PIXEL_BITS'(1);
  assign cx = PIXEL_BITS'(col) + PIXEL_BITS'(1);
  // x*10 as x*8 + x*2 keeps this multiplier-free
  assign coord = (ly << 3) + (ly << 1) + cx;
  assign value = pattern == PAT_RAMP  ? pix :
                 pattern == PAT_COORD ? coord :
                 pattern == PAT_CHECK ? {PIXEL_BITS{line[0] ^ col[0]}} : frame_id;
endmodule

// File: rtl/camera_sim.sv
// camera_sim: MT9V034-style FRAME_VALID/LINE_VALID/10-bit raster source with test patterns.
// Define CAMERA_SIM_BLANK_ZERO_EN to force DATA_OUT to 0 while LINE_VALID is low.
module camera_sim
  import camera_pkg::*;
#(
  parameter int WIDTH    = 752,
  parameter int HEIGHT   = 480,
  parameter int H_BLANK  = 94,
  parameter int FV_TO_LV = 0,
  parameter int V_BLANK  = 45
) (
  input  logic                  PIXCLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [1:0]            PATTERN,
  output logic                  FRAME_VALID,
  output logic                  LINE_VALID,
  output logic [PIXEL_BITS-1:0] DATA_OUT,
  output logic                  FRAME_DONE
);
  localparam int CW   = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int LW   = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam int BMAX = max3(H_BLANK, V_BLANK, FV_TO_LV);
  localparam int BW   = BMAX > 1 ? $clog2(BMAX) : 1;
  state_t state, state_n;
  logic [CW-1:0] col, col_n;
  logic [LW-1:0] line, line_n;
  logic [BW-1:0] cnt, cnt_n;
  logic [PIXEL_BITS-1:0] pix, pix_n, frame_id, frame_id_n, value;
  logic [1:0] pat, pat_n;
  logic done, start;
  camera_sim_pattern #(.LW(LW), .CW(CW)) u_pattern (
    .pattern(pat), .line(line), .col(col), .pix(pix), .frame_id(frame_id), .value(value)
  );
  always_comb begin
    state_n = state;
    col_n = col;
    line_n = line;
    cnt_n = '0;
    pix_n = pix;
    pat_n = pat;
    frame_id_n = frame_id;
    done = 1'b0;
    start = ENABLE && (state == IDLE || (state == VBLANK && cnt == BW'(V_BLANK - 1)));
    case (state)
      FRONT:
        if (cnt == BW'(FV_TO_LV - 1)) state_n = LINE;
        else cnt_n = cnt + BW'(1);
      LINE: begin
        pix_n = pix + PIXEL_BITS'(1);
        col_n = col == CW'(WIDTH - 1) ? '0 : col + CW'(1);
        state_n = col == CW'(WIDTH - 1) ? HBLANK : LINE;
      end
      HBLANK:
        if (cnt != BW'(H_BLANK - 1)) cnt_n = cnt + BW'(1);
        else if (line == LW'(HEIGHT - 1)) begin
          line_n = '0;
          state_n = VBLANK;
          done = 1'b1;
          frame_id_n = frame_id + PIXEL_BITS'(1);
        end else begin
          line_n = line + LW'(1);
          state_n = LINE;
        end
      VBLANK:
        if (cnt != BW'(V_BLANK - 1)) cnt_n = cnt + BW'(1);
        else state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // ENABLE and PATTERN only matter at a frame boundary
    if (start) begin
      state_n = FV_TO_LV == 0 ? LINE : FRONT;
      pat_n = PATTERN;
      pix_n = '0;
      cnt_n = '0;
    end
  end
  always_ff @(posedge PIXCLK) begin
    if (RESET) begin
      state <= IDLE;
      col <= '0;
      line <= '0;
      cnt <= '0;
      pix <= '0;
      pat <= '0;
      frame_id <= '0;
      FRAME_VALID <= 1'b0;
      LINE_VALID <= 1'b0;
      DATA_OUT <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      state <= state_n;
      col <= col_n;
      line <= line_n;
      cnt <= cnt_n;
      pix <= pix_n;
      pat <= pat_n;
      frame_id <= frame_id_n;
      FRAME_VALID <= state inside {FRONT, LINE, HBLANK};
      LINE_VALID <= state == LINE;
      FRAME_DONE <= done;
`ifdef CAMERA_SIM_BLANK_ZERO_EN
      DATA_OUT <= state == LINE ? value : '0;
`else
      if (state == LINE) DATA_OUT <= value;
`endif
    end
  end
endmodule

// File: tb/tb_camera_sim.sv
// tb_camera_sim: directed checks of raster timing, patterns, reset abort and blank-data behaviour
module tb_camera_sim;
  logic clk = 1'b0, rst = 1'b1, en_a = 1'b0, en_b = 1'b0;
  logic [1:0] pat_a = 2'b00, pat_b = 2'b00;
  logic fv_a, lv_a, fd_a, fv_b, lv_b, fd_b;
  logic [9:0] d_a, d_b;
  int checks = 0, errs = 0;
  int last, v, lv, l, c2;
`ifdef CAMERA_SIM_BLANK_ZERO_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif
  always #5 clk = ~clk;
  camera_sim #(.WIDTH(2), .HEIGHT(3), .H_BLANK(1), .FV_TO_LV(0), .V_BLANK(2)) dut_a (
    .PIXCLK(clk), .RESET(rst), .ENABLE(en_a), .PATTERN(pat_a),
    .FRAME_VALID(fv_a), .LINE_VALID(lv_a), .DATA_OUT(d_a), .FRAME_DONE(fd_a)
  );
  camera_sim #(.WIDTH(4), .HEIGHT(2), .H_BLANK(1), .FV_TO_LV(3), .V_BLANK(2)) dut_b (
    .PIXCLK(clk), .RESET(rst), .ENABLE(en_b), .PATTERN(pat_b),
    .FRAME_VALID(fv_b), .LINE_VALID(lv_b), .DATA_OUT(d_b), .FRAME_DONE(fd_b)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic check_idle_a(input string tag, input int data);
    check({tag, "_fv"}, fv_a, 0);
    check({tag, "_lv"}, lv_a, 0);
    check({tag, "_fd"}, fd_a, 0);
    check({tag, "_data"}, d_a, data);
  endtask
  initial begin
    // reset state
    tick;
    tick;
    check_idle_a("rst", 0);
    check("rst_b_fv", fv_b, 0);
    check("rst_b_data", d_b, 0);
    // single frame, coordinate pattern; ENABLE and PATTERN change during line 0
    rst = 1'b0; en_a = 1'b1; pat_a = 2'b01;
    tick;
    check("t1_start_fv", fv_a, 0);
    en_a = 1'b0; pat_a = 2'b10;
    last = 0;
    for (int c = 0; c < 9; c++) begin
      tick;
      lv = int'((c % 3) != 2);
      v = ((c / 3) + 1) * 10 + (c % 3) + 1;
      if (lv != 0) last = v;
      check("t1_fv", fv_a, 1);
      check("t1_lv", lv_a, lv);
      check("t1_fd", fd_a, int'(c == 8));
      check("t1_data", d_a, lv != 0 ? v : (BZ ? 0 : last));
    end
    for (int c = 0; c < 6; c++) begin
      tick;
      check_idle_a("t1_after", BZ ? 0 : 32);
    end
    // continuous frames, frame-id pattern
    rst = 1'b1;
    tick;
    check_idle_a("t2_rst", 0);
    rst = 1'b0; en_a = 1'b1; pat_a = 2'b11;
    tick;
    check("t2_start_fv", fv_a, 0);
    last = 0;
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 11; c++) begin
        tick;
        lv = int'(c < 9 && (c % 3) != 2);
        if (lv != 0) last = f;
        check("t2_fv", fv_a, int'(c < 9));
        check("t2_lv", lv_a, lv);
        check("t2_fd", fd_a, int'(c == 8));
        check("t2_data", d_a, lv != 0 ? f : (BZ ? 0 : last));
      end
    // reset mid-frame at line 1 col 0, ramp pattern
    rst = 1'b1;
    tick;
    rst = 1'b0; pat_a = 2'b00;
    tick;
    check("t3_start_fv", fv_a, 0);
    tick;
    check("t3_d0", d_a, 0);
    tick;
    check("t3_d1", d_a, 1);
    tick;
    check("t3_hb", d_a, BZ ? 0 : 1);
    tick;
    check("t3_lv_l1", lv_a, 1);
    check("t3_d2", d_a, 2);
    rst = 1'b1;
    tick;
    check_idle_a("t3_abort", 0);
    rst = 1'b0;
    tick;
    check("t3_restart_fv", fv_a, 0);
    tick;
    check("t3_new_fv", fv_a, 1);
    check("t3_new_lv", lv_a, 1);
    check("t3_new_d0", d_a, 0);
    en_a = 1'b0;
    tick;
    check("t3_new_d1", d_a, 1);
    for (int c = 0; c < 12; c++) tick;
    check("t3_end_fv", fv_a, 0);
    // front porch and checker pattern on the wider raster
    en_b = 1'b1; pat_b = 2'b10;
    tick;
    check("t5_start_fv", fv_b, 0);
    en_b = 1'b0; pat_b = 2'b01;
    last = 0;
    for (int c = 0; c < 13; c++) begin
      tick;
      lv = int'(c >= 3 && c != 7 && c < 12);
      l = c < 7 ? 0 : 1;
      c2 = c < 7 ? c - 3 : c - 8;
      v = ((l ^ c2) & 1) != 0 ? 10'h3FF : 0;
      if (lv != 0) last = v;
      check("t5_fv", fv_b, 1);
      check("t5_lv", lv_b, lv);
      check("t5_fd", fd_b, int'(c == 12));
      check("t5_data", d_b, lv != 0 ? v : (BZ ? 0 : last));
    end
    for (int c = 0; c < 5; c++) begin
      tick;
      check("t5_after_fv", fv_b, 0);
      check("t5_after_lv", lv_b, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule

// File: doc/camera_sim.md
Name: camera_sim

Overview:
- Synthesizable MT9V034-style parallel-video source. It is the transmit end of the FRAME_VALID/LINE_VALID/10-bit pixel bus that the camera receiver consumes.
- Generates a parameterized frame/line raster with deterministic test patterns.
- Used for on-chip loopback into the receiver and for bench stimulus without a sensor.

Parameters:
- WIDTH, 752, active pixels per line (>=1)
- HEIGHT, 480, active lines per frame (>=1)
- H_BLANK, 94, LINE_VALID-low cycles after every line, including the last (>=1)
- FV_TO_LV, 0, FRAME_VALID-high/LINE_VALID-low cycles before first line (>=0)
- V_BLANK, 45, FRAME_VALID-low cycles between frames (>=1)

Ports:
- PIXCLK  in  1  pixel clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  start/continue frame generation
- PATTERN  in  2  pattern select, latched at frame start
- FRAME_VALID  out  1  frame envelope
- LINE_VALID  out  1  active-pixel qualifier
- DATA_OUT  out  10  pixel data
- FRAME_DONE  out  1  one-cycle pulse on the last FRAME_VALID-high cycle

Behaviour:
- Reset:
  - All outputs are 0 on the edge after RESET is sampled high. RESET mid-frame aborts immediately.
  - State goes to IDLE; counters and the frame counter clear.
- All outputs are registered; no combinational input-to-output paths.
- States and transitions:
  - IDLE (FV=0, LV=0): ENABLE sampled high at edge N → FRONT (or LINE if FV_TO_LV=0) outputs visible after edge N+1. PATTERN is latched on that same edge.
  - FRONT (FV=1, LV=0): FV_TO_LV cycles → LINE.
  - LINE (FV=1, LV=1): WIDTH cycles, col 0..WIDTH-1 → HBLANK.
  - HBLANK (FV=1, LV=0): H_BLANK cycles. Then → LINE with line+1, or, on the last line, → VBLANK. FRAME_DONE=1 on the final HBLANK cycle of the last line.
  - VBLANK (FV=0, LV=0): V_BLANK cycles. Then, if ENABLE=1, → new frame (same start rule as IDLE); else → IDLE.
- Frame period = HEIGHT*(WIDTH+H_BLANK) + FV_TO_LV + V_BLANK cycles.
- Output invariants: LINE_VALID is never high while FRAME_VALID is low. FRAME_VALID never starts mid-line.
- ENABLE deasserted mid-frame: the current frame completes in full, including VBLANK; ENABLE is only consulted at frame start.
- PATTERN changes mid-frame are ignored until the next frame start.
- Patterns (line/col are 0-based, results truncated to 10 bits):
  - 00 ramp: pixel index within frame (line*WIDTH+col), restarts at 0 each frame, wraps mod 1024.
  - 01 coordinate: (line+1)*10 + (col+1), computed with shifts/adds only (x*8 + x*2). Example: 11, 12, 21, 22.
  - 10 checker: 10'h3FF when line[0]^col[0], else 10'h000.
  - 11 frame id: frame counter low 10 bits, constant for the whole frame. The counter increments on each FRAME_DONE and wraps.
- Counter widths: max(1, $clog2(WIDTH)) and max(1, $clog2(HEIGHT)). Terminal-count compares use WIDTH-1/HEIGHT-1, so there are no overflow wraps.
- DATA_OUT during LINE_VALID=0: see optional feature.

Optional Feature:
- Macro: CAMERA_SIM_BLANK_ZERO_EN
- Defined: DATA_OUT is forced to 0 on every cycle LINE_VALID=0, including reset and IDLE.
- Undefined: DATA_OUT holds the last pixel driven, or 0 after reset. This models real sensor bus hold.
- LV/FV timing is identical either way.

Decomposition:
- Package camera_pkg holds:
  - state enum (IDLE, FRONT, LINE, HBLANK, VBLANK)
  - pattern codes (PAT_RAMP=2'b00, PAT_COORD=2'b01, PAT_CHECK=2'b10, PAT_FRAMEID=2'b11)
  - PIXEL_BITS=10
- Sub-module camera_sim_pattern: combinational pixel value from (pattern, line, col, pixel index, frame id), registered by the parent. The timing FSM and counters stay in camera_sim.

Test Plan:
- WIDTH=2, HEIGHT=3, H_BLANK=1, FV_TO_LV=0, V_BLANK=2, PATTERN=01, ENABLE pulsed 1 cycle after reset:
  - FV high for exactly 9 cycles
  - LV pattern 1,1,0,1,1,0,1,1,0
  - DATA on LV: 11,12,21,22,31,32
  - FRAME_DONE on cycle 9 only
  - returns to IDLE
- Same params, ENABLE held high, PATTERN=11:
  - period 11 cycles
  - frame ids 0,1,2 on successive frames
  - exactly 2 FV-low cycles between frames
- Feed output into the camera receiver (#(3,2)), PATTERN=00:
  - receiver PIXEL_VALID asserted 6 times per frame
  - DATA_OUT 0..5 with matching CURRENT_LINE/CURRENT_COLUMN
- RESET asserted during line 1 col 0:
  - next edge all outputs 0
  - with ENABLE=1 after release, a fresh frame starts at line 0, ramp 0
- ENABLE dropped during line 0, PATTERN changed 01→10 mid-frame:
  - frame finishes with coordinate values
  - no new frame starts; FV stays 0
- FV_TO_LV=3, PATTERN=10, WIDTH=4, HEIGHT=2:
  - 3 FV-high/LV-low cycles before first LV
  - DATA 000,3FF,000,3FF then 3FF,000,3FF,000
  - blank-cycle DATA=0 with CAMERA_SIM_BLANK_ZERO_EN, held value without it
